// File: rtl/invsqrt_arbiter_if.sv
// invsqrt_arbiter_if: requester, shared-unit and response signals of invsqrt_arbiter
interface invsqrt_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
);
    logic [NUM_REQ-1:0]    req_valid;
    logic [16*NUM_REQ-1:0] req_data;
    logic [NUM_REQ-1:0]    req_ready;
    logic [15:0]           unit_xin;
    logic                  unit_start;
    logic                  unit_done;
    logic [15:0]           unit_result;
    logic [1:0]            unit_ofuf;
    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [ID_W-1:0]       rsp_id;
    logic [15:0]           rsp_data;
    logic [1:0]            rsp_ofuf;
    logic                  rsp_timeout;

    modport master (
        input  req_valid, req_data, unit_done, unit_result, unit_ofuf, rsp_ready,
        output req_ready, unit_xin, unit_start, rsp_valid, rsp_id, rsp_data, rsp_ofuf, rsp_timeout
    );

    modport slave (
        output req_valid, req_data, unit_done, unit_result, unit_ofuf, rsp_ready,
        input  req_ready, unit_xin, unit_start, rsp_valid, rsp_id, rsp_data, rsp_ofuf, rsp_timeout
    );
endinterface

// File: rtl/invsqrt_arbiter.sv
// invsqrt_arbiter: round-robin sharing of one iterative inverse-sqrt unit among NUM_REQ requesters
// Defining INVSQRT_ARB_STATS_EN adds saturating completion/timeout counters stat_done and stat_timeout.
module invsqrt_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2,
    parameter int TIMEOUT = 63
) (
    input  logic clk,
    input  logic reset,
    invsqrt_arbiter_if.master bus,
    output logic busy
`ifdef INVSQRT_ARB_STATS_EN
    ,
    output logic [15:0] stat_done,
    output logic [15:0] stat_timeout
`endif
);
    typedef enum logic [1:0] {IDLE, START, WAIT, RESP} state_t;

    state_t          state, state_n;
    logic [ID_W-1:0] rr_ptr, id, grant;
    logic [7:0]      wait_cnt;
    logic [15:0]     op, r_data;
    logic [1:0]      r_ofuf;
    logic            r_timeout, any, done_ok, to_hit;
    logic [15:0]     lane [NUM_REQ];

    function automatic logic [ID_W-1:0] wrap(input int v);
        return ID_W'(v % NUM_REQ);
    endfunction

    if (2**ID_W < NUM_REQ) begin : g_id_check
        $error("ID_W too narrow for NUM_REQ");
    end

    for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
        assign lane[i] = bus.req_data[16*i +: 16];
    end

    // Smallest offset from rr_ptr wins: scan offsets downward so the last hit stands.
    always_comb begin
        grant = rr_ptr;
        any   = 1'b0;
        for (int k = NUM_REQ - 1; k >= 0; k--)
            if (bus.req_valid[wrap(int'(rr_ptr) + k)]) begin
                grant = wrap(int'(rr_ptr) + k);
                any   = 1'b1;
            end
    end

    // A done still high from the previous operation is ignored in the first WAIT cycle.
    assign done_ok = bus.unit_done && wait_cnt != 8'd0;
    assign to_hit  = wait_cnt == 8'(TIMEOUT);

    always_comb begin
        state_n = state;
        case (state)
            IDLE:    state_n = any ? START : IDLE;
            START:   state_n = WAIT;
            WAIT:    state_n = (done_ok || to_hit) ? RESP : WAIT;
            RESP:    state_n = bus.rsp_ready ? IDLE : RESP;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            wait_cnt  <= '0;
            op        <= '0;
            id        <= '0;
            r_data    <= '0;
            r_ofuf    <= '0;
            r_timeout <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && any) begin
                op <= lane[grant];
                id <= grant;
            end
            if (state == START)
                wait_cnt <= '0;
            else if (state == WAIT && !to_hit)
                wait_cnt <= wait_cnt + 8'd1;
            if (state == WAIT && done_ok)
                {r_data, r_ofuf, r_timeout} <= {bus.unit_result, bus.unit_ofuf, 1'b0};
            else if (state == WAIT && to_hit)
                {r_data, r_ofuf, r_timeout} <= {16'h7E00, 2'b00, 1'b1};
            if (state == RESP && bus.rsp_ready)
                rr_ptr <= wrap(int'(id) + 1);
        end
    end

    assign bus.req_ready   = (state == IDLE && any && !reset) ? NUM_REQ'(1) << grant : '0;
    assign bus.unit_start  = state == START && !reset;
    assign bus.unit_xin    = op;
    assign bus.rsp_valid   = state == RESP && !reset;
    assign bus.rsp_id      = id;
    assign bus.rsp_data    = r_data;
    assign bus.rsp_ofuf    = r_ofuf;
    assign bus.rsp_timeout = r_timeout;
    assign busy            = state != IDLE && !reset;

`ifdef INVSQRT_ARB_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            stat_done    <= '0;
            stat_timeout <= '0;
        end else begin
            stat_done    <= stat_done + 16'(state == WAIT && done_ok && stat_done != 16'hFFFF);
            stat_timeout <= stat_timeout + 16'(state == WAIT && !done_ok && to_hit && stat_timeout != 16'hFFFF);
        end
    end
`endif
endmodule

// File: tb/tb_invsqrt_arbiter.sv
// tb_invsqrt_arbiter: vector table plus corner sequences against a behavioural inverse-sqrt unit
module tb_invsqrt_arbiter;
    logic clk = 1'b0;
    logic reset = 1'b1;
    logic busy;
    always #5 clk = ~clk;

    invsqrt_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus ();
`ifdef INVSQRT_ARB_STATS_EN
    logic [15:0] stat_done, stat_timeout;
`endif

    invsqrt_arbiter #(.NUM_REQ(4), .ID_W(2), .TIMEOUT(63)) dut (
        .clk(clk),
        .reset(reset),
        .bus(bus),
        .busy(busy)
`ifdef INVSQRT_ARB_STATS_EN
        ,
        .stat_done(stat_done),
        .stat_timeout(stat_timeout)
`endif
    );

    typedef struct packed {
        logic [1:0]  id;
        logic [15:0] data;
        logic [1:0]  ofuf;
        logic        to;
    } rsp_t;

    typedef struct {
        logic [3:0] mask;
        rsp_t       exp;
    } vec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          starts = 0;
    rsp_t        q[$];
    rsp_t        e_m;
    logic [15:0] exp_xin = '0;
    logic [15:0] ops [4];
    vec_t        vt [9];

    // Behavioural unit: done after unit_delay cycles, held until the next start.
    int          unit_delay = 20;
    logic        hang = 1'b0;
    logic        stale = 1'b0;
    logic [15:0] u_op;
    logic [7:0]  u_cnt, u_age;
    logic        u_done;

    function automatic logic [17:0] lut(input logic [15:0] x);
        case (x)
            16'h50BB: return {16'h3133, 2'b00};
            16'h4DE1: return {16'h3298, 2'b01};
            16'h71C0: return {16'h20B7, 2'b10};
            16'h0DB4: return {16'h52B2, 2'b11};
            default:  return {16'hFFFF, 2'b00};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset || bus.unit_start) begin
            u_op   <= bus.unit_xin;
            u_cnt  <= 8'(unit_delay);
            u_done <= 1'b0;
            u_age  <= '0;
        end else begin
            u_age <= u_age + 8'd1;
            if (u_cnt > 8'd1)
                u_cnt <= u_cnt - 8'd1;
            else if (u_cnt == 8'd1) begin
                u_cnt  <= '0;
                u_done <= !hang;
            end
        end
    end

    logic [17:0] u_lut;
    assign u_lut           = lut(u_op);
    assign bus.unit_done   = stale | u_done;
    assign bus.unit_result = stale ? (16'h4000 | {8'h00, u_age}) : u_done ? u_lut[17:2] : 16'hDEAD;
    assign bus.unit_ofuf   = stale ? 2'b10 : u_done ? u_lut[1:0] : 2'b11;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (bus.unit_start) begin
            starts++;
            chk("unit_xin", 64'(bus.unit_xin), 64'(exp_xin));
        end
        if (bus.rsp_valid && bus.rsp_ready) begin
            if (q.size() == 0)
                chk("rsp_unexpected", 64'(bus.rsp_valid), 64'd0);
            else begin
                e_m = q.pop_front();
                chk("rsp_fields", 64'({bus.rsp_id, bus.rsp_data, bus.rsp_ofuf, bus.rsp_timeout}), 64'(e_m));
            end
        end
    end

    task automatic grant(input string nm, input logic [3:0] mask, input logic [1:0] id, output bit ok);
        int n;
        @(posedge clk);
        #1 bus.req_valid = mask;
        for (n = 0; n < 50; n++) begin
            @(negedge clk);
            if (|(bus.req_valid & bus.req_ready)) break;
        end
        ok = n < 50;
        chk({nm, "_grant"}, 64'(bus.req_ready), 64'(4'b0001 << id));
        exp_xin = ops[id];
        @(posedge clk);
        #1 bus.req_valid = '0;
    endtask

    task automatic wait_rsp(input string nm);
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (q.size() == 0) return;
        end
        chk({nm, "_rsp_pending"}, 64'(q.size()), 64'd0);
        q.delete();
    endtask

    task automatic do_txn(input string nm, input logic [3:0] mask, input rsp_t e);
        bit ok;
        int s0;
        s0 = starts;
        grant(nm, mask, e.id, ok);
        if (!ok) return;
        q.push_back(e);
        wait_rsp(nm);
        chk({nm, "_starts"}, 64'(starts - s0), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "global timeout");
    end

    initial begin
        bit   ok;
        int   n, s0;
        rsp_t snap;
        logic seen;
        ops = '{16'h50BB, 16'h4DE1, 16'h71C0, 16'h0DB4};
        vt[0] = '{4'b0001, '{2'd0, 16'h3133, 2'b00, 1'b0}};
        vt[1] = '{4'b1111, '{2'd1, 16'h3298, 2'b01, 1'b0}};
        vt[2] = '{4'b1111, '{2'd2, 16'h20B7, 2'b10, 1'b0}};
        vt[3] = '{4'b1111, '{2'd3, 16'h52B2, 2'b11, 1'b0}};
        vt[4] = '{4'b0001, '{2'd0, 16'h3133, 2'b00, 1'b0}};
        vt[5] = '{4'b1001, '{2'd3, 16'h52B2, 2'b11, 1'b0}};
        vt[6] = '{4'b0110, '{2'd1, 16'h3298, 2'b01, 1'b0}};
        vt[7] = '{4'b0011, '{2'd0, 16'h3133, 2'b00, 1'b0}};
        vt[8] = '{4'b1111, '{2'd1, 16'h3298, 2'b01, 1'b0}};
        bus.req_data  = {ops[3], ops[2], ops[1], ops[0]};
        bus.req_valid = 4'b1111;
        bus.rsp_ready = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_ctrl", 64'({busy, bus.req_ready, bus.unit_start, bus.rsp_valid}), 64'd0);
        chk("reset_data", 64'({bus.unit_xin, bus.rsp_id, bus.rsp_data, bus.rsp_ofuf, bus.rsp_timeout}), 64'd0);
`ifdef INVSQRT_ARB_STATS_EN
        chk("reset_stats", 64'({stat_done, stat_timeout}), 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b0;
        bus.req_valid = '0;

        for (int i = 0; i < 9; i++)
            do_txn($sformatf("vec%0d", i), vt[i].mask, vt[i].exp);

        // Backpressure: response held for 10 cycles while every requester asks.
        bus.rsp_ready = 1'b0;
        s0 = starts;
        grant("bp", 4'b0100, 2'd2, ok);
        q.push_back('{2'd2, 16'h20B7, 2'b10, 1'b0});
        for (n = 0; n < 100; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        chk("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        snap = '{bus.rsp_id, bus.rsp_data, bus.rsp_ofuf, bus.rsp_timeout};
        @(posedge clk);
        #1 bus.req_valid = 4'b1111;
        repeat (10) begin
            @(negedge clk);
            chk("bp_hold", 64'({bus.rsp_valid, bus.req_ready, bus.unit_start, bus.rsp_id, bus.rsp_data, bus.rsp_ofuf, bus.rsp_timeout}),
                64'({1'b1, 4'b0000, 1'b0, snap}));
        end
        chk("bp_starts", 64'(starts - s0), 64'd1);
        @(posedge clk);
        #1 bus.req_valid = '0;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("bp_release", 64'({busy, bus.rsp_valid}), 64'd0);
        chk("bp_drained", 64'(q.size()), 64'd0);

        // Stale done: result must be taken at wait_cnt == 1, when the unit shows age 1.
        stale = 1'b1;
        do_txn("stale", 4'b0010, '{2'd1, 16'h4001, 2'b10, 1'b0});
        stale = 1'b0;

        // Watchdog: unit never finishes.
        hang = 1'b1;
        grant("wd", 4'b0100, 2'd2, ok);
        q.push_back('{2'd2, 16'h7E00, 2'b00, 1'b1});
        @(negedge clk);
        chk("wd_start", 64'(bus.unit_start), 64'd1);
        for (n = 0; n < 300; n++) begin
            @(negedge clk);
            if (bus.rsp_valid) break;
        end
        chk("wd_wait_cycles", 64'(n), 64'd64);
`ifdef INVSQRT_ARB_STATS_EN
        chk("wd_stats", 64'({stat_done, stat_timeout}), 64'({16'd11, 16'd1}));
`endif
        wait_rsp("wd");
        hang = 1'b0;

        // Reset in the middle of WAIT: no response, pointer back to 0.
        grant("rst", 4'b0010, 2'd1, ok);
        repeat (6) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        chk("rst_during", 64'({busy, bus.rsp_valid, bus.unit_start, bus.req_ready}), 64'd0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_after", 64'({busy, bus.rsp_valid}), 64'd0);
`ifdef INVSQRT_ARB_STATS_EN
        chk("rst_stats", 64'({stat_done, stat_timeout}), 64'd0);
`endif
        seen = 1'b0;
        repeat (40) begin
            @(negedge clk);
            seen = seen | bus.rsp_valid | busy;
        end
        chk("rst_quiet", 64'(seen), 64'd0);
        do_txn("rst_next", 4'b1111, '{2'd0, 16'h3133, 2'b00, 1'b0});
`ifdef INVSQRT_ARB_STATS_EN
        chk("end_stats", 64'({stat_done, stat_timeout}), 64'({16'd1, 16'd0}));
`endif
        chk("end_drained", 64'(q.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/invsqrt_arbiter.md
Name: invsqrt_arbiter

Overview:
- Shares one iterative 16-bit half-precision inverse-square-root unit among NUM_REQ requesters.
- Grants requesters round-robin, latches the operand and drives it to the unit. Issues the unit's start/reset pulse, waits for its done, then returns the result tagged with the requester ID.
- Sits between the FPU request ports and the single shared fast-inverse-sqrt core.
- Includes a watchdog so that a hung unit cannot lock the resource.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, width of the requester ID; must satisfy 2**ID_W >= NUM_REQ.
- TIMEOUT, 63, maximum WAIT cycles before the operation is aborted (1..255).

Ports:
- clk  in  1  clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high.
- req_valid  in  NUM_REQ  per-requester operand valid.
- req_data  in  16*NUM_REQ  operands; requester i uses bits [16i+15:16i].
- req_ready  out  NUM_REQ  one-hot grant/accept.
- unit_xin  out  16  operand to the unit, held stable from START through WAIT.
- unit_start  out  1  one-cycle pulse wired to the unit's reset/start input.
- unit_done  in  1  unit completion flag.
- unit_result  in  16  unit result.
- unit_ofuf  in  2  unit overflow/underflow flags.
- rsp_valid  out  1  response valid.
- rsp_ready  in  1  response accept.
- rsp_id  out  ID_W  index of the requester that owns the response.
- rsp_data  out  16  result.
- rsp_ofuf  out  2  flags.
- rsp_timeout  out  1  set when the response was produced by watchdog abort.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset values: state = IDLE, rr_ptr = 0, wait_cnt = 0, and every output is 0 (unit_xin = 0, req_ready = 0, unit_start = 0, rsp_* = 0, busy = 0).
- Reset asserted mid-operation aborts immediately, with no response issued. unit_start stays 0 during reset.
- FSM states: IDLE, START, WAIT, RESP.
- IDLE:
  - Winner g = first i with req_valid[i] set, searching from rr_ptr upward with wrap.
  - req_ready = one-hot(g) is combinational, asserted only in IDLE and only if some req_valid is set.
  - On the handshake cycle: latch op = req_data[g] and id = g, then go to START.
- START:
  - unit_start = 1 for exactly one cycle; unit_xin = op.
  - Clear wait_cnt; go to WAIT.
- WAIT:
  - wait_cnt increments every cycle, 8-bit, no wrap beyond TIMEOUT.
  - unit_done is ignored while wait_cnt == 0 (stale-done guard) and sampled from wait_cnt >= 1.
  - On done: latch rsp_data = unit_result and rsp_ofuf = unit_ofuf, rsp_timeout = 0, then go to RESP.
  - Else if wait_cnt == TIMEOUT: rsp_data = 16'h7E00 (qNaN), rsp_ofuf = 2'b00, rsp_timeout = 1, then go to RESP.
  - If done and timeout occur in the same cycle, done wins.
- RESP:
  - rsp_valid = 1 and rsp_id = id; all rsp_* fields stay stable until rsp_ready.
  - On rsp_valid & rsp_ready: rr_ptr = (id + 1) mod NUM_REQ, then go to IDLE. rsp_valid drops in the next cycle.
- Only one operation is in flight at a time; no new grant is issued until the response handshakes.
- Best-case latency from accept to rsp_valid: 3 cycles plus unit compute time.
- A requester that drops req_valid without a handshake is simply not granted; no state is kept.
- The rr_ptr wrap from NUM_REQ-1 goes to 0.

Optional Feature:
- Macro INVSQRT_ARB_STATS_EN.
- When defined, adds two outputs, stat_done (16) and stat_timeout (16).
  - Both are saturating counters, incremented on each WAIT->RESP transition (normal completion and timeout respectively).
  - Both clear on reset and hold at 16'hFFFF once reached.
- When undefined, these ports and their logic do not exist; all other behaviour is identical.

Test Plan:
- Single request: req_valid[0] with 16'h50BB, behavioural unit returning done after 20 cycles -> exactly one unit_start pulse with unit_xin = 16'h50BB; response rsp_id = 0, rsp_data = 16'h3133, rsp_timeout = 0.
- Round robin: all four requesters valid simultaneously (0x50BB, 0x4DE1, 0x71C0, 0x0DB4), rsp_ready tied to 1 -> grants in order 0,1,2,3; rsp_data 0x3133, 0x3298, 0x20B7, 0x52B2. Then requester 0 alone re-asserts -> it is granted next.
- Backpressure: hold rsp_ready = 0 for 10 cycles while in RESP -> rsp fields stable, req_ready stays 0, no unit_start issued; release -> IDLE on the next cycle.
- Watchdog: unit never asserts done, TIMEOUT = 63 -> rsp_valid appears 64 cycles after START with rsp_data = 16'h7E00 and rsp_timeout = 1. With the stats macro on: stat_timeout = 1, stat_done = 0.
- Stale done: unit_done held at 1 across START -> ignored at wait_cnt == 0; the response is taken at wait_cnt == 1 with the current unit_result.
- Reset mid-WAIT: assert reset for one cycle -> busy = 0, no rsp_valid, rr_ptr = 0. The next request is served normally.
